// File: rtl/sudoku_board_overlay.sv
// Sudoku board overlay: draws grid lines, cursor highlight and digit glyphs over the
// background pixel stream, keeping pixel, sync and valid aligned over 3 clock cycles.
module sudoku_board_overlay #(
    parameter int X0   = 104,
    parameter int Y0   = 24,
    parameter int CELL = 48,
    parameter int GX   = 16,
    parameter int GY   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] bg_pixel,
    input  logic        wr_en,
    input  logic [6:0]  wr_index,
    input  logic [3:0]  wr_digit,
    input  logic        clear,
    input  logic [6:0]  cursor_index,
    output logic [11:0] pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        valid_out
);
    localparam int OW  = $clog2(CELL);
    localparam int OW1 = OW + 1;

    localparam logic [9:0]         X_LO   = 10'(X0);
    localparam logic [9:0]         X_HI   = 10'(X0 + 9 * CELL);
    localparam logic [9:0]         Y_LO   = 10'(Y0);
    localparam logic [9:0]         Y_HI   = 10'(Y0 + 9 * CELL);
    localparam logic [OW-1:0]      O_LAST = OW'(CELL - 1);
    localparam logic [OW-1:0]      O_EDGE = OW'(CELL - 2);
    localparam logic signed [OW:0] GX_S   = OW1'(GX);
    localparam logic signed [OW:0] GY_S   = OW1'(GY);
    localparam logic signed [OW:0] GW_S   = OW1'(16);
    localparam logic signed [OW:0] GH_S   = OW1'(32);

    // Advance a cell/offset tracker by one pixel; the cell index wraps after 8 so a
    // tracker that starts unaligned (e.g. after reset mid-frame) never indexes off the board.
    function automatic logic [OW+3:0] step(input logic [3:0] c, input logic [OW-1:0] o);
        if (o == O_LAST)
            return {((c == 4'd8) ? 4'd0 : c + 4'd1), {OW{1'b0}}};
        return {c, o + OW'(1)};
    endfunction

    // Thick lines at box edges (cells 0,3,6 and the far edge of cell 8), thin elsewhere.
    function automatic logic on_line(input logic [3:0] c, input logic [OW-1:0] o);
        return (o == '0)
            || ((o == OW'(1)) && ((c == 4'd0) || (c == 4'd3) || (c == 4'd6)))
            || ((c == 4'd8) && (o >= O_EDGE));
    endfunction

    // 8x16 digit font, row 0 in the most significant byte; leftmost pixel is bit 7.
    function automatic logic [7:0] glyph_row(input logic [3:0] digit, input logic [3:0] row);
        logic [127:0] g;
        case (digit)
            4'd1:    g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'd2:    g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'd3:    g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'd4:    g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'd5:    g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'd6:    g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'd7:    g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'd8:    g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'd9:    g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            default: g = '0;
        endcase
        return g[{4'd15 - row, 3'b000} +: 8];
    endfunction

    logic [3:0] board [81];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 81; i++) board[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 81; i++) board[i] <= '0;
        end else if (wr_en && (wr_index <= 7'd80) && (wr_digit <= 4'd9)) begin
            board[wr_index] <= wr_digit;
        end
    end

    // Stage 1: cell/offset tracking and board window
    logic          in_h, in_v;
    logic [3:0]    cx_p0, cy_p0;
    logic [OW-1:0] ox_p0, oy_p0;
    logic          in_board_p0, vld_p0, hs_p0, vs_p0;

    assign in_h = (h_cnt >= X_LO) && (h_cnt < X_HI);
    assign in_v = (v_cnt >= Y_LO) && (v_cnt < Y_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx_p0       <= '0;
            ox_p0       <= '0;
            cy_p0       <= '0;
            oy_p0       <= '0;
            in_board_p0 <= 1'b0;
            vld_p0      <= 1'b0;
            hs_p0       <= 1'b0;
            vs_p0       <= 1'b0;
        end else begin
            if (h_cnt == X_LO) begin
                cx_p0 <= '0;
                ox_p0 <= '0;
            end else if (in_h) begin
                {cx_p0, ox_p0} <= step(cx_p0, ox_p0);
            end
            if (h_cnt == 10'd0) begin
                if (v_cnt == Y_LO) begin
                    cy_p0 <= '0;
                    oy_p0 <= '0;
                end else if (in_v) begin
                    {cy_p0, oy_p0} <= step(cy_p0, oy_p0);
                end
            end
            in_board_p0 <= in_h && in_v;
            vld_p0      <= valid_in;
            hs_p0       <= hsync_in;
            vs_p0       <= vsync_in;
        end
    end

    // Stage 2: board read, glyph coordinates, grid and cursor decode
    logic [6:0]           cell_idx;
    logic signed [OW:0]   gx_off, gy_off;
    logic                 in_glyph;
    logic [3:0]           digit_p1, gr_p1;
    logic [2:0]           gc_p1;
    logic                 glyph_p1, grid_p1, cur_p1;
    logic                 in_board_p1, vld_p1, hs_p1, vs_p1;
    logic [11:0]          bg_p1;

    assign cell_idx = 7'(cy_p0) * 7'd9 + 7'(cx_p0);
    assign gx_off   = $signed({1'b0, ox_p0}) - GX_S;
    assign gy_off   = $signed({1'b0, oy_p0}) - GY_S;
    assign in_glyph = !gx_off[OW] && (gx_off < GW_S) && !gy_off[OW] && (gy_off < GH_S);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_p1    <= '0;
            gr_p1       <= '0;
            gc_p1       <= '0;
            glyph_p1    <= 1'b0;
            grid_p1     <= 1'b0;
            cur_p1      <= 1'b0;
            in_board_p1 <= 1'b0;
            vld_p1      <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
            bg_p1       <= '0;
        end else begin
            digit_p1    <= board[cell_idx];
            gr_p1       <= gy_off[4:1];
            gc_p1       <= gx_off[3:1];
            glyph_p1    <= in_glyph;
            grid_p1     <= on_line(cx_p0, ox_p0) || on_line(cy_p0, oy_p0);
            cur_p1      <= (cursor_index == cell_idx);
            in_board_p1 <= in_board_p0;
            vld_p1      <= vld_p0;
            hs_p1       <= hs_p0;
            vs_p1       <= vs_p0;
            bg_p1       <= bg_pixel;
        end
    end

    // Stage 3: layer priority and output register
    logic [7:0]  row_bits;
    logic        ink;
    logic [11:0] pix_d;
    logic [11:0] pixel_p2;
    logic        vld_p2, hs_p2, vs_p2;

    always_comb begin
        row_bits = glyph_row(digit_p1, gr_p1);
        ink      = row_bits[3'd7 - gc_p1];
        pix_d    = bg_p1;
        if (!vld_p1)
            pix_d = 12'h000;
        else if (!in_board_p1)
            pix_d = bg_p1;
        else if (grid_p1)
            pix_d = 12'h000;
        else if ((digit_p1 >= 4'd1) && (digit_p1 <= 4'd9) && glyph_p1 && ink)
            pix_d = 12'h00F;
        else if (cur_p1)
            pix_d = 12'hFE8;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_p2 <= '0;
            vld_p2   <= 1'b0;
            hs_p2    <= 1'b0;
            vs_p2    <= 1'b0;
        end else begin
            pixel_p2 <= pix_d;
            vld_p2   <= vld_p1;
            hs_p2    <= hs_p1;
            vs_p2    <= vs_p1;
        end
    end

    assign pixel_out = pixel_p2;
    assign hsync_out = hs_p2;
    assign vsync_out = vs_p2;
    assign valid_out = vld_p2;

endmodule

// File: doc/sudoku_board_overlay.md
Name: sudoku_board_overlay

Overview:
- Pixel-pipeline stage directly downstream of the VGA timing generator and the background-image block RAM, upstream of the RGB output pins.
- Holds the 9x9 Sudoku digit board in registers and draws grid lines, a cursor highlight and digit glyphs over the background pixel.
- Delays sync and valid so they stay aligned with the output pixel.
- Runs on the 25 MHz pixel clock.

Parameters:
- X0, 104, left pixel column of the board.
- Y0, 24, top pixel row of the board.
- CELL, 48, cell size in pixels (board is 9*CELL square).
- GX, 16, glyph x offset inside a cell.
- GY, 8, glyph y offset inside a cell.

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- h_cnt  in  10  current pixel column (0..639 visible)
- v_cnt  in  10  current pixel row (0..479 visible)
- valid_in  in  1  visible-area flag, aligned with h_cnt/v_cnt
- hsync_in  in  1  horizontal sync, aligned with h_cnt
- vsync_in  in  1  vertical sync, aligned with h_cnt
- bg_pixel  in  12  background RGB444; arrives 1 cycle after its h_cnt/v_cnt (block RAM latency)
- wr_en  in  1  board write strobe
- wr_index  in  7  cell index row*9+col, 0..80
- wr_digit  in  4  0 = empty, 1..9 = digit
- clear  in  1  synchronous clear of all 81 cells
- cursor_index  in  7  highlighted cell; values >=81 mean no cursor
- pixel_out  out  12  output RGB444
- hsync_out  out  1  hsync_in delayed 3 cycles
- vsync_out  out  1  vsync_in delayed 3 cycles
- valid_out  out  1  valid_in delayed 3 cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - All board cells 0.
  - Cell/offset trackers 0.
  - Pipeline registers 0.
- Latency: exactly 3 clk from an h_cnt/v_cnt sample to its pixel_out; hsync, vsync and valid get identical 3-stage delay; bg_pixel gets 2 stages.
- Stage 1, position tracking (no dividers):
  - Column: registered cx (0..8) and ox (0..CELL-1). When h_cnt==X0, load 0,0. Otherwise, while inside the board, increment ox; on wrap CELL-1 -> 0, increment cx.
  - Row: cy/oy update only when h_cnt==0. When v_cnt==Y0, load 0,0. Otherwise, while inside the board, increment with the same wrap rule.
  - in_board = X0 <= h_cnt < X0+9*CELL and Y0 <= v_cnt < Y0+9*CELL, registered alongside the trackers.
- Stage 2: read digit = board[cy*9+cx]; compute glyph row gr = (oy-GY)>>1 and glyph column gc = (ox-GX)>>1; glyph window is 16x32 px (8x16 ROM scaled x2).
- Stage 3, priority (highest first):
  - valid=0 -> 12'h000.
  - Outside the board -> bg_pixel.
  - Grid line -> 12'h000. Grid line means ox==0; or ox==1 with cx in {0,3,6}; or cx==8 and ox>=CELL-2. Same rules for the y axis.
  - Digit 1..9, inside the glyph window, ROM bit set -> 12'h00F.
  - Cell == cursor_index -> 12'hFE8.
  - Otherwise bg_pixel.
- Glyph ROM:
  - Internal, 9 digits x 16 rows x 8 bits, combinational.
  - The bit for column gc is bit [7-gc].
- Board writes:
  - wr_en with wr_index<=80 and wr_digit<=9 updates the cell at the clock edge. Any other wr_index or wr_digit value is ignored.
  - clear and wr_en in the same cycle: clear wins, all cells 0.
  - Read during write: the pixel in flight uses the old value; the new value is visible from the next cycle.
- cursor_index is sampled in stage 2 and can change at any time; it has no effect on board contents.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, correct alignment resumes from the next h_cnt==X0 / v_cnt==Y0 load.

Test Plan:
- Reset, then run 1 frame with bg_pixel=12'h5A5 and empty board -> pixel_out=12'h5A5 outside grid lines; hsync_out/vsync_out equal inputs delayed exactly 3 clk.
- Pixel (X0+24, Y0+24) with cursor_index=0 and board empty -> pixel_out=12'hFE8 exactly 3 clk after that h_cnt/v_cnt.
- Same pixel with cursor_index=81 -> pixel_out=12'h5A5.
- Write digit 1 to index 40, drive pixel at an ink bit of the "1" glyph in cell (4,4) -> 12'h00F.
- Drive a non-ink glyph pixel of the same cell -> bg_pixel.
- Pixels h_cnt=X0 and X0+1 (thick line) -> 12'h000. Pixel X0+CELL+1 (thin line, not a box edge) -> background.
- wr_en=1, wr_index=5, wr_digit=7 together with clear=1 -> cell 5 reads 0 afterwards.
- Write wr_digit=12 -> cell unchanged.
- Write wr_index=90 -> no cell changes.
- Assert rst low mid-line -> all outputs 0 asynchronously and board cleared. After release, first full frame renders identically to the first scenario.
